// File: rtl/arm_run_pkg.sv
// Shared types and default parameters for the ARM core run controller.
package arm_run_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 16;

   // Controller state encoding (also exported on the state port)
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      CLR  = 3'd1,
      RUN  = 3'd2,
      PASS = 3'd3,
      FAIL = 3'd4
   } run_state_t;

   localparam logic [XLEN-1:0]  PC_LIMIT_DEF   = 32'd100;
   localparam logic [XLEN-1:0]  CHECK_ADDR_DEF = 32'd100;
   localparam logic [XLEN-1:0]  CHECK_DATA_DEF = 32'd7;
   localparam logic [CNT_W-1:0] TIMEOUT_DEF    = 16'd1024;

   // Increment that sticks at all-ones instead of wrapping
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/run_store_monitor.sv
// Decodes committed stores against the check address/data and captures the last store.
module run_store_monitor
   import arm_run_pkg::*;
#(
   parameter logic [XLEN-1:0] CHECK_ADDR = CHECK_ADDR_DEF,
   parameter logic [XLEN-1:0] CHECK_DATA = CHECK_DATA_DEF
) (
   input  logic            clk_50Mhz,
   input  logic            reset,
   input  logic            clear,
   input  logic            commit,
   input  logic [XLEN-1:0] adr,
   input  logic [XLEN-1:0] data,
   output logic            match_pass,
   output logic            match_fail,
   output logic [XLEN-1:0] last_adr,
   output logic [XLEN-1:0] last_data
);

   logic [XLEN-1:0] last_adr_q,  last_adr_d;
   logic [XLEN-1:0] last_data_q, last_data_d;

   // Classify a committed store to the check address by its data
   always_comb begin
      match_pass = 1'b0;
      match_fail = 1'b0;
      if (commit && (adr == CHECK_ADDR)) begin
         match_pass = (data == CHECK_DATA);
         match_fail = (data != CHECK_DATA);
      end
   end

   // Capture every committed store; a run restart wipes the capture
   always_comb begin
      last_adr_d  = last_adr_q;
      last_data_d = last_data_q;
      if (clear) begin
         last_adr_d  = '0;
         last_data_d = '0;
      end else if (commit) begin
         last_adr_d  = adr;
         last_data_d = data;
      end
   end

   // Capture registers
   always_ff @(posedge clk_50Mhz or negedge reset) begin
      if (!reset) begin
         last_adr_q  <= '0;
         last_data_q <= '0;
      end else begin
         last_adr_q  <= last_adr_d;
         last_data_q <= last_data_d;
      end
   end

   assign last_adr  = last_adr_q;
   assign last_data = last_data_q;

endmodule

// File: rtl/arm_run_ctrl.sv
// Run controller: sequences the core through reset, free-run/single-step and halt,
// gates the core with a synchronous enable and judges pass/fail from stores.
module arm_run_ctrl
   import arm_run_pkg::*;
#(
   parameter logic [XLEN-1:0]  PC_LIMIT   = PC_LIMIT_DEF,
   parameter logic [XLEN-1:0]  CHECK_ADDR = CHECK_ADDR_DEF,
   parameter logic [XLEN-1:0]  CHECK_DATA = CHECK_DATA_DEF,
   parameter logic [CNT_W-1:0] TIMEOUT    = TIMEOUT_DEF
) (
   input  logic             clk_50Mhz,
   input  logic             reset,
   input  logic             start,
   input  logic             run_mode,
   input  logic             step,
   input  logic [XLEN-1:0]  PC,
   input  logic             MemWrite,
   input  logic [XLEN-1:0]  DataAdr,
   input  logic [XLEN-1:0]  WriteData,
   output logic             cpu_en,
   output logic             cpu_rst,
   output logic [2:0]       state,
   output logic             led_success,
   output logic             led_fail,
   output logic [CNT_W-1:0] cycle_count,
   output logic [XLEN-1:0]  last_adr,
   output logic [XLEN-1:0]  last_data
);

   localparam logic [CNT_W-1:0] LAST_CYCLE = TIMEOUT - CNT_W'(1);

   run_state_t       state_q, state_d;
   logic             clr_cnt_q, clr_cnt_d;
   logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
   logic             cpu_rst_q, cpu_rst_d;
   logic             led_success_q, led_success_d;
   logic             led_fail_q, led_fail_d;

   logic             commit_c;
   logic             clear_c;
   logic             match_pass_c;
   logic             match_fail_c;

   // Core clock enable: live only in RUN, gated by step in single-step mode
   always_comb begin
      cpu_en = 1'b0;
      if (state_q == RUN) begin
         cpu_en = run_mode | step;
      end
   end

   assign commit_c = MemWrite & cpu_en;
   assign clear_c  = (state_d == CLR);

   run_store_monitor #(
      .CHECK_ADDR (CHECK_ADDR),
      .CHECK_DATA (CHECK_DATA)
   ) u_store_mon (
      .clk_50Mhz  (clk_50Mhz),
      .reset      (reset),
      .clear      (clear_c),
      .commit     (commit_c),
      .adr        (DataAdr),
      .data       (WriteData),
      .match_pass (match_pass_c),
      .match_fail (match_fail_c),
      .last_adr   (last_adr),
      .last_data  (last_data)
   );

   // Next state, CLR length counter and enabled-cycle counter
   always_comb begin
      state_d       = state_q;
      clr_cnt_d     = clr_cnt_q;
      cycle_count_d = cycle_count_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = CLR;
               clr_cnt_d = 1'b0;
            end
         end
         CLR: begin
            clr_cnt_d = 1'b1;
            if (clr_cnt_q) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (start) begin
               state_d   = CLR;
               clr_cnt_d = 1'b0;
            end else if (cpu_en) begin
               cycle_count_d = sat_inc(cycle_count_q);
               if (match_pass_c) begin
                  state_d = PASS;
               end else if (match_fail_c || (PC > PC_LIMIT) ||
                            (cycle_count_q == LAST_CYCLE)) begin
                  state_d = FAIL;
               end
            end
         end
         PASS, FAIL: begin
            if (start) begin
               state_d   = CLR;
               clr_cnt_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (state_d == CLR) begin
         cycle_count_d = '0;
      end
   end

   // Registered status outputs follow the state being entered
   always_comb begin
      cpu_rst_d     = (state_d == IDLE) || (state_d == CLR);
      led_success_d = (state_d == PASS);
      led_fail_d    = (state_d == FAIL);
   end

   // State and output registers
   always_ff @(posedge clk_50Mhz or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         clr_cnt_q     <= 1'b0;
         cycle_count_q <= '0;
         cpu_rst_q     <= 1'b1;
         led_success_q <= 1'b0;
         led_fail_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         clr_cnt_q     <= clr_cnt_d;
         cycle_count_q <= cycle_count_d;
         cpu_rst_q     <= cpu_rst_d;
         led_success_q <= led_success_d;
         led_fail_q    <= led_fail_d;
      end
   end

   assign state       = state_q;
   assign cpu_rst     = cpu_rst_q;
   assign led_success = led_success_q;
   assign led_fail    = led_fail_q;
   assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_arm_run_ctrl.sv
// Self-checking bench for arm_run_ctrl: directed vector table, corner sequences
// and randomized traffic against a behavioural model.
module tb_arm_run_ctrl;

   localparam int unsigned S_IDLE = 0, S_CLR = 1, S_RUN = 2, S_PASS = 3, S_FAIL = 4;
   localparam int unsigned K_PCL  = 100;
   localparam int unsigned K_ADR  = 100;
   localparam int unsigned K_DAT  = 7;
   localparam int unsigned K_TO   = 1024;

   logic        clk;
   logic        reset;
   logic        start, run_mode, step, MemWrite;
   logic [31:0] PC, DataAdr, WriteData;
   logic        cpu_en, cpu_rst, led_success, led_fail;
   logic [2:0]  state;
   logic [15:0] cycle_count;
   logic [31:0] last_adr, last_data;

   int n_pass = 0;
   int n_total = 0;

   arm_run_ctrl dut (
      .clk_50Mhz   (clk),
      .reset       (reset),
      .start       (start),
      .run_mode    (run_mode),
      .step        (step),
      .PC          (PC),
      .MemWrite    (MemWrite),
      .DataAdr     (DataAdr),
      .WriteData   (WriteData),
      .cpu_en      (cpu_en),
      .cpu_rst     (cpu_rst),
      .state       (state),
      .led_success (led_success),
      .led_fail    (led_fail),
      .cycle_count (cycle_count),
      .last_adr    (last_adr),
      .last_data   (last_data)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Behavioural model: phase, remaining clear cycles, enabled-cycle tally, last store
   int unsigned m_phase;
   int unsigned m_clr_left;
   int unsigned m_cycles;
   int unsigned m_adr, m_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
   endtask

   task automatic model_reset();
      m_phase = S_IDLE; m_clr_left = 0; m_cycles = 0; m_adr = 0; m_data = 0;
   endtask

   function automatic logic model_en(input logic rm, input logic stp);
      return (m_phase == S_RUN) && (rm || stp);
   endfunction

   task automatic model_edge(input logic s, input logic rm, input logic stp, input logic [31:0] pc,
                             input logic mw, input logic [31:0] adr, input logic [31:0] data);
      logic        en;
      int unsigned prior;
      en = model_en(rm, stp);
      if (s && m_phase != S_CLR) begin
         m_phase = S_CLR; m_clr_left = 2; m_cycles = 0; m_adr = 0; m_data = 0;
      end else if (m_phase == S_CLR) begin
         m_clr_left--;
         if (m_clr_left == 0) m_phase = S_RUN;
      end else if (en) begin
         prior = m_cycles;
         if (m_cycles < 65535) m_cycles++;
         if (mw) begin m_adr = adr; m_data = data; end
         if (mw && adr == K_ADR) m_phase = (data == K_DAT) ? S_PASS : S_FAIL;
         else if (pc > K_PCL) m_phase = S_FAIL;
         else if (prior + 1 == K_TO) m_phase = S_FAIL;
      end
   endtask

   task automatic check_regs();
      chk("state", 32'(state), 32'(m_phase));
      chk("cpu_rst", 32'(cpu_rst), 32'(m_phase == S_IDLE || m_phase == S_CLR));
      chk("led_success", 32'(led_success), 32'(m_phase == S_PASS));
      chk("led_fail", 32'(led_fail), 32'(m_phase == S_FAIL));
      chk("cycle_count", 32'(cycle_count), m_cycles);
      chk("last_adr", last_adr, m_adr);
      chk("last_data", last_data, m_data);
   endtask

   // One clock: drive at negedge, check the enable mid-cycle, check registers at next negedge
   task automatic do_cycle(input logic s, input logic rm, input logic stp, input logic [31:0] pc,
                           input logic mw, input logic [31:0] adr, input logic [31:0] data,
                           output logic en_seen);
      start = s; run_mode = rm; step = stp; PC = pc; MemWrite = mw; DataAdr = adr; WriteData = data;
      #1;
      en_seen = cpu_en;
      chk("cpu_en", 32'(cpu_en), 32'(model_en(rm, stp)));
      @(posedge clk);
      model_edge(s, rm, stp, pc, mw, adr, data);
      @(negedge clk);
      check_regs();
   endtask

   task automatic begin_run(input logic rm);
      logic e;
      do_cycle(1'b1, rm, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, e);
      do_cycle(1'b0, rm, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, e);
      do_cycle(1'b0, rm, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, e);
   endtask

   typedef struct {
      logic        s, rm, stp;
      logic [31:0] pc;
      logic        mw;
      logic [31:0] adr, data;
      logic        e_en;
      logic [2:0]  e_state;
      logic        e_succ, e_fail;
      logic [15:0] e_cnt;
      logic [31:0] e_data;
   } vec_t;

   vec_t tbl[12];

   initial begin
      logic e;
      int   n_en;

      tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'd0,   1'b0, 32'd0,   32'd0, 1'b0, 3'd1, 1'b0, 1'b0, 16'd0, 32'd0};
      tbl[1]  = '{1'b0, 1'b1, 1'b0, 32'd0,   1'b0, 32'd0,   32'd0, 1'b0, 3'd1, 1'b0, 1'b0, 16'd0, 32'd0};
      tbl[2]  = '{1'b0, 1'b1, 1'b0, 32'd0,   1'b0, 32'd0,   32'd0, 1'b0, 3'd2, 1'b0, 1'b0, 16'd0, 32'd0};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, 32'd0,   1'b0, 32'd0,   32'd0, 1'b1, 3'd2, 1'b0, 1'b0, 16'd1, 32'd0};
      tbl[4]  = '{1'b0, 1'b1, 1'b0, 32'd4,   1'b1, 32'd50,  32'd3, 1'b1, 3'd2, 1'b0, 1'b0, 16'd2, 32'd3};
      tbl[5]  = '{1'b0, 1'b1, 1'b0, 32'd8,   1'b1, 32'd100, 32'd7, 1'b1, 3'd3, 1'b1, 1'b0, 16'd3, 32'd7};
      tbl[6]  = '{1'b0, 1'b1, 1'b0, 32'd12,  1'b0, 32'd0,   32'd0, 1'b0, 3'd3, 1'b1, 1'b0, 16'd3, 32'd7};
      tbl[7]  = '{1'b1, 1'b1, 1'b0, 32'd0,   1'b0, 32'd0,   32'd0, 1'b0, 3'd1, 1'b0, 1'b0, 16'd0, 32'd0};
      tbl[8]  = '{1'b0, 1'b1, 1'b0, 32'd0,   1'b0, 32'd0,   32'd0, 1'b0, 3'd1, 1'b0, 1'b0, 16'd0, 32'd0};
      tbl[9]  = '{1'b0, 1'b1, 1'b0, 32'd0,   1'b0, 32'd0,   32'd0, 1'b0, 3'd2, 1'b0, 1'b0, 16'd0, 32'd0};
      tbl[10] = '{1'b0, 1'b1, 1'b0, 32'd0,   1'b1, 32'd100, 32'd5, 1'b1, 3'd4, 1'b0, 1'b1, 16'd1, 32'd5};
      tbl[11] = '{1'b0, 1'b1, 1'b0, 32'd200, 1'b1, 32'd100, 32'd7, 1'b0, 3'd4, 1'b0, 1'b1, 16'd1, 32'd5};

      reset = 1'b0; start = 1'b0; run_mode = 1'b0; step = 1'b0;
      PC = '0; MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
      model_reset();
      @(negedge clk); @(negedge clk);
      chk("rst_state", 32'(state), 32'(S_IDLE));
      chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
      chk("rst_cpu_en", 32'(cpu_en), 32'd0);
      chk("rst_led_success", 32'(led_success), 32'd0);
      chk("rst_led_fail", 32'(led_fail), 32'd0);
      chk("rst_cycle_count", 32'(cycle_count), 32'd0);
      chk("rst_last_adr", last_adr, 32'd0);
      chk("rst_last_data", last_data, 32'd0);
      reset = 1'b1;

      // Directed vectors: pass run, restart, failing store, frozen after halt
      for (int i = 0; i < 12; i++) begin
         do_cycle(tbl[i].s, tbl[i].rm, tbl[i].stp, tbl[i].pc, tbl[i].mw, tbl[i].adr, tbl[i].data, e);
         chk($sformatf("tbl%0d_en", i), 32'(e), 32'(tbl[i].e_en));
         chk($sformatf("tbl%0d_state", i), 32'(state), 32'(tbl[i].e_state));
         chk($sformatf("tbl%0d_succ", i), 32'(led_success), 32'(tbl[i].e_succ));
         chk($sformatf("tbl%0d_fail", i), 32'(led_fail), 32'(tbl[i].e_fail));
         chk($sformatf("tbl%0d_cnt", i), 32'(cycle_count), 32'(tbl[i].e_cnt));
         chk($sformatf("tbl%0d_data", i), last_data, tbl[i].e_data);
      end

      // PC ramp: PC=100 is still legal, PC=104 fails on that enabled cycle
      begin_run(1'b1);
      for (int pc = 0; pc <= 104; pc += 4) begin
         do_cycle(1'b0, 1'b1, 1'b0, 32'(pc), 1'b0, 32'd0, 32'd0, e);
         chk($sformatf("ramp_pc%0d", pc), 32'(state), (pc < 104) ? 32'(S_RUN) : 32'(S_FAIL));
      end

      // Single-step: three isolated pulses, then step held for four cycles
      begin_run(1'b0);
      n_en = 0;
      for (int i = 0; i < 9; i++) begin
         do_cycle(1'b0, 1'b0, (i % 3 == 1), 32'd0, 1'b0, 32'd0, 32'd0, e);
         n_en += int'(e);
      end
      chk("step_en_cycles", 32'(n_en), 32'd3);
      chk("step_count", 32'(cycle_count), 32'd3);
      chk("step_state", 32'(state), 32'(S_RUN));
      for (int i = 0; i < 4; i++) do_cycle(1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 32'd0, 32'd0, e);
      do_cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, e);
      chk("step_held_count", 32'(cycle_count), 32'd7);

      // Timeout: free-run without termination, then restart clears
      begin_run(1'b1);
      n_en = 0;
      for (int i = 0; i < 1100 && state != 3'(S_FAIL); i++) begin
         do_cycle(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, e);
         n_en += int'(e);
      end
      chk("timeout_state", 32'(state), 32'(S_FAIL));
      chk("timeout_en_cycles", 32'(n_en), 32'(K_TO));
      do_cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, e);
      chk("restart_clr1", 32'(state), 32'(S_CLR));
      chk("restart_cnt", 32'(cycle_count), 32'd0);
      chk("restart_led_fail", 32'(led_fail), 32'd0);
      do_cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, e);
      chk("restart_clr2", 32'(state), 32'(S_CLR));
      do_cycle(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, e);
      chk("restart_run", 32'(state), 32'(S_RUN));

      // Asynchronous reset in the middle of a run
      for (int i = 0; i < 3; i++) do_cycle(1'b0, 1'b1, 1'b0, 32'd4, 1'b1, 32'd60, 32'd9, e);
      #5 reset = 1'b0;
      #1;
      chk("arst_state", 32'(state), 32'(S_IDLE));
      chk("arst_cpu_rst", 32'(cpu_rst), 32'd1);
      chk("arst_cpu_en", 32'(cpu_en), 32'd0);
      chk("arst_cycle_count", 32'(cycle_count), 32'd0);
      chk("arst_last_adr", last_adr, 32'd0);
      chk("arst_last_data", last_data, 32'd0);
      model_reset();
      @(negedge clk);
      reset = 1'b1;

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         logic        s, rm, stp, mw;
         logic [31:0] pc, adr, data;
         s    = ($urandom_range(0, 40) == 0);
         rm   = ($urandom_range(0, 3) != 0);
         stp  = 1'($urandom);
         pc   = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(90, 200)) : 32'($urandom_range(0, 96));
         mw   = ($urandom_range(0, 3) == 0);
         adr  = ($urandom_range(0, 5) == 0) ? 32'(K_ADR) : 32'($urandom_range(0, 200));
         data = ($urandom_range(0, 1) == 0) ? 32'(K_DAT) : 32'($urandom_range(0, 15));
         do_cycle(s, rm, stp, pc, mw, adr, data, e);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
